decode_regfile_stage: RTL

- Parametrised successor to the combinational decode/register-mapping block.
- Splits a MIPS instruction into its fields, reads two operands from a clocked register file with write-back port and write-through bypass, and extends the immediate according to opcode.
- Registers everything into an ID/EX pipeline register with valid, stall and flush control.
- Sits between the IF stage and the EX stage; the write port is driven from WB.

---
 rtl/decode_regfile_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/decode_regfile_stage.sv
// ID stage: splits a MIPS instruction, reads two operands from a clocked register file
// with write-through bypass, extends the immediate, and registers everything into ID/EX.
module decode_regfile_stage #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = $clog2(NUM_REGS),
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       inst_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    output logic [5:0]        opcode_o,
    output logic [ADDR_W-1:0] rs_o,
    output logic [ADDR_W-1:0] rt_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [4:0]        shamt_o,
    output logic [5:0]        funct_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs_idx;
    logic [ADDR_W-1:0] rt_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              wr_allowed;

    assign opcode = inst_in[31:26];
    assign rs_idx = inst_in[21 +: ADDR_W];
    assign rt_idx = inst_in[16 +: ADDR_W];
    assign rd_idx = inst_in[11 +: ADDR_W];
    assign imm16  = inst_in[15:0];

    assign wr_allowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else if (wr_allowed) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Zero-register check precedes bypass so a dropped write to reg 0 is never forwarded.
    always_comb begin
        rd_data_1 = regs[rs_idx];
        rd_data_2 = regs[rt_idx];
        if ((BYPASS != 0) && wr_allowed && (wr_addr == rs_idx)) rd_data_1 = wr_data;
        if ((BYPASS != 0) && wr_allowed && (wr_addr == rt_idx)) rd_data_2 = wr_data;
        if ((ZERO_REG != 0) && (rs_idx == '0)) rd_data_1 = '0;
        if ((ZERO_REG != 0) && (rt_idx == '0)) rd_data_2 = '0;
    end

    always_comb begin
        imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm_ext = {{(DATA_W-16){1'b0}}, imm16};
            6'h0F:               imm_ext = {{(DATA_W-32){1'b0}}, imm16, 16'h0000};
            default:             ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            opcode_o  <= '0;
            rs_o      <= '0;
            rt_o      <= '0;
            rd_o      <= '0;
            shamt_o   <= '0;
            funct_o   <= '0;
            imm_o     <= '0;
            data_1    <= '0;
            data_2    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            opcode_o  <= opcode;
            rs_o      <= rs_idx;
            rt_o      <= rt_idx;
            rd_o      <= rd_idx;
            shamt_o   <= inst_in[10:6];
            funct_o   <= inst_in[5:0];
            imm_o     <= imm_ext;
            data_1    <= rd_data_1;
            data_2    <= rd_data_2;
        end
    end

endmodule
